// File: rtl/ysyx_25040105_mc_ctrl_if.sv
// Instruction and data memory handshake bundle for the multi-cycle sequencer.
// master: the core sequencer; slave: the memory / bus model.
interface ysyx_25040105_mc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_we;
  logic [XLEN-1:0] dmem_req_addr;
  logic            dmem_rsp_valid;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dmem_req_valid, dmem_req_we, dmem_req_addr,
    input  dmem_req_ready, dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dmem_req_valid, dmem_req_we, dmem_req_addr,
    output dmem_req_ready, dmem_rsp_valid
  );
endinterface

// File: rtl/ysyx_25040105_mc_ctrl.sv
// Multi-cycle core sequencer: owns PC and instruction register, walks each
// instruction through fetch / execute / memory / writeback over valid-ready
// memory handshakes, and reports retirement and halt status.
module ysyx_25040105_mc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25040105_mc_ctrl_if.master       bus,
  output logic [31:0]                   inst,
  output logic [XLEN-1:0]               pc,
  input  logic                          dec_is_load,
  input  logic                          dec_is_store,
  input  logic                          dec_is_ebreak,
  input  logic                          dec_jump_en,
  input  logic                          dec_reg_wen,
  input  logic [XLEN-1:0]               exu_jump_addr,
  input  logic [XLEN-1:0]               exu_mem_addr,
  input  logic                          a0_is_zero,
  output logic                          rf_wen,
  output logic                          rf_wsel_mem,
  output logic                          commit_valid,
  output logic [XLEN-1:0]               commit_pc,
  output logic                          halted,
  output logic [1:0]                    exit_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_F_REQ, S_F_WAIT, S_EXEC, S_M_REQ, S_M_WAIT, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    EXIT_GOOD, EXIT_BAD, EXIT_TIMEOUT, EXIT_MISALIGN
  } exit_t;

  localparam int unsigned   WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  state_t          state;
  logic [WDW-1:0]  wdog;
  logic            imem_req_valid_q;
  logic [XLEN-1:0] next_pc;

  assign next_pc = dec_jump_en ? exu_jump_addr : pc + XLEN'(4);

  assign bus.imem_req_valid = imem_req_valid_q;
  assign bus.imem_req_addr  = pc;

  // Data request and RF strobes follow the live decode inputs in their state.
  always_comb begin
    bus.dmem_req_valid = (state == S_M_REQ);
    bus.dmem_req_we    = (state == S_M_REQ) & dec_is_store;
    bus.dmem_req_addr  = exu_mem_addr;
    rf_wen             = (state == S_WB) & dec_reg_wen & ~dec_is_store;
    rf_wsel_mem        = (state == S_WB) & dec_is_load;
  end

  // Sequencer FSM with registered fetch valid, commit and halt outputs.
  // The watchdog is cleared by default and only advances while a wait state holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pc               <= RESET_PC;
      inst             <= '0;
      wdog             <= '0;
      imem_req_valid_q <= 1'b0;
      commit_valid     <= 1'b0;
      commit_pc        <= '0;
      halted           <= 1'b0;
      exit_code        <= '0;
    end else begin
      commit_valid <= 1'b0;
      wdog         <= '0;
      case (state)
        S_IDLE: begin
          state            <= S_F_REQ;
          imem_req_valid_q <= (pc[1:0] == 2'b00);
        end
        S_F_REQ: begin
          if (pc[1:0] != 2'b00) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            exit_code <= EXIT_MISALIGN;
          end else if (bus.imem_req_ready) begin
            state            <= S_F_WAIT;
            imem_req_valid_q <= 1'b0;
          end else if (wdog == WDOG_LAST) begin
            state            <= S_HALT;
            halted           <= 1'b1;
            exit_code        <= EXIT_TIMEOUT;
            imem_req_valid_q <= 1'b0;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        S_F_WAIT: begin
          if (bus.imem_rsp_valid) begin
            inst  <= bus.imem_rsp_data;
            state <= S_EXEC;
          end else if (wdog == WDOG_LAST) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            exit_code <= EXIT_TIMEOUT;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        S_EXEC: begin
          if (dec_is_ebreak) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            exit_code <= a0_is_zero ? EXIT_GOOD : EXIT_BAD;
          end else if (dec_is_load | dec_is_store) begin
            state <= S_M_REQ;
          end else begin
            state        <= S_WB;
            commit_valid <= 1'b1;
            commit_pc    <= pc;
          end
        end
        S_M_REQ: begin
          if (bus.dmem_req_ready) begin
            state <= S_M_WAIT;
          end else if (wdog == WDOG_LAST) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            exit_code <= EXIT_TIMEOUT;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        S_M_WAIT: begin
          if (bus.dmem_rsp_valid) begin
            state        <= S_WB;
            commit_valid <= 1'b1;
            commit_pc    <= pc;
          end else if (wdog == WDOG_LAST) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            exit_code <= EXIT_TIMEOUT;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        S_WB: begin
          pc               <= next_pc;
          state            <= S_F_REQ;
          imem_req_valid_q <= (next_pc[1:0] == 2'b00);
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_mc_ctrl.sv
// Bench for the multi-cycle sequencer: a directed vector table, randomized
// instruction stream against a PC / latency reference model, and hand-written
// halt, timeout and reset sequences.
module tb_ysyx_25040105_mc_ctrl;
  localparam int XLEN = 32;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_JUMP, K_EBREAK} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] target;
    logic [31:0] maddr;
    logic        wen;
    logic        a0z;
    int          wf, wr, wm, wd;
  } inst_t;

  typedef struct {
    inst_t       i;
    logic [31:0] exp_addr;
    logic [31:0] exp_cpc;
    int          exp_cyc;
    logic        exp_wen;
    logic        exp_wsel;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25040105_mc_ctrl_if #(.XLEN(XLEN)) bus();

  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            dec_is_load, dec_is_store, dec_is_ebreak, dec_jump_en, dec_reg_wen;
  logic [XLEN-1:0] exu_jump_addr, exu_mem_addr;
  logic            a0_is_zero;
  logic            rf_wen, rf_wsel_mem, commit_valid, halted;
  logic [XLEN-1:0] commit_pc;
  logic [1:0]      exit_code;

  ysyx_25040105_mc_ctrl #(.XLEN(XLEN), .RESET_PC(32'h8000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .inst(inst), .pc(pc),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_ebreak(dec_is_ebreak),
    .dec_jump_en(dec_jump_en), .dec_reg_wen(dec_reg_wen),
    .exu_jump_addr(exu_jump_addr), .exu_mem_addr(exu_mem_addr), .a0_is_zero(a0_is_zero),
    .rf_wen(rf_wen), .rf_wsel_mem(rf_wsel_mem),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .halted(halted), .exit_code(exit_code)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_commits = 0;
  vec_t vq[$];

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Count every retirement pulse to detect extra commits.
  always @(negedge clk) if (commit_valid === 1'b1) n_commits++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input kind_t k);
    case (k)
      K_LOAD:   return 32'h0000_2003;
      K_STORE:  return 32'h0000_2023;
      K_JUMP:   return 32'h0000_006f;
      K_EBREAK: return 32'h0010_0073;
      default:  return 32'h0000_0013;
    endcase
  endfunction

  function automatic inst_t mk(input kind_t k, input logic [31:0] tgt, input logic [31:0] ma,
                               input logic wen, input logic a0z,
                               input int wf, input int wr, input int wm, input int wd);
    inst_t t;
    t.kind = k; t.target = tgt; t.maddr = ma; t.wen = wen; t.a0z = a0z;
    t.wf = wf; t.wr = wr; t.wm = wm; t.wd = wd;
    return t;
  endfunction

  // Reference rules: next PC, instruction latency, RF write strobes.
  function automatic logic [31:0] model_next_pc(input inst_t t, input logic [31:0] p);
    return (t.kind == K_JUMP) ? t.target : p + 32'd4;
  endfunction

  function automatic int model_cycles(input inst_t t);
    int c;
    c = 4 + t.wf + t.wr;
    if (t.kind == K_LOAD || t.kind == K_STORE) c = c + 2 + t.wm + t.wd;
    return c;
  endfunction

  task automatic add_vec(input inst_t t, input logic [31:0] a, input logic [31:0] cpc,
                         input int c, input logic wen, input logic wsel);
    vec_t v;
    v.i = t; v.exp_addr = a; v.exp_cpc = cpc; v.exp_cyc = c; v.exp_wen = wen; v.exp_wsel = wsel;
    vq.push_back(v);
  endtask

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0;
    dec_jump_en = 1'b0; dec_reg_wen = 1'b0;
    exu_jump_addr = '0; exu_mem_addr = '0; a0_is_zero = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_valid", bus.imem_req_valid, 1'b0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_exit_code", exit_code, 2'd0);
    chk("rst_commit", commit_valid, 1'b0);
    chk("rst_dmem_valid", bus.dmem_req_valid, 1'b0);
    chk("rst_rf_wen", rf_wen, 1'b0);
    rst = 1'b0;
  endtask

  // Plays the memory and decoder for one instruction, starting from a pending fetch.
  task automatic do_inst(input inst_t t, input logic [31:0] exp_addr,
                         output logic [31:0] o_cpc, output int o_cyc,
                         output logic o_wen, output logic o_wsel, output logic o_commit);
    int n;
    int t0;
    n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_valid", bus.imem_req_valid, 1'b1);
    chk("fetch_addr", bus.imem_req_addr, exp_addr);
    t0 = cyc;
    for (int k = 0; k < t.wf; k++) begin
      bus.imem_req_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", bus.imem_req_valid, 1'b1);
      chk("stall_addr", bus.imem_req_addr, exp_addr);
    end
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk("fetch_drop", bus.imem_req_valid, 1'b0);
    dec_is_load   = (t.kind == K_LOAD);
    dec_is_store  = (t.kind == K_STORE);
    dec_is_ebreak = (t.kind == K_EBREAK);
    dec_jump_en   = (t.kind == K_JUMP);
    dec_reg_wen   = t.wen;
    exu_jump_addr = t.target;
    exu_mem_addr  = t.maddr;
    a0_is_zero    = t.a0z;
    for (int k = 0; k < t.wr; k++) @(negedge clk);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = word_of(t.kind);
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk("inst_latch", inst, word_of(t.kind));
    o_cpc = '0; o_wen = 1'b0; o_wsel = 1'b0;
    if (t.kind == K_EBREAK) begin
      @(negedge clk);
      o_commit = commit_valid;
      o_cyc = cyc - t0 + 1;
      return;
    end
    @(negedge clk);
    if (t.kind == K_LOAD || t.kind == K_STORE) begin
      chk("dmem_valid", bus.dmem_req_valid, 1'b1);
      chk("dmem_we", bus.dmem_req_we, t.kind == K_STORE);
      chk("dmem_addr", bus.dmem_req_addr, t.maddr);
      for (int k = 0; k < t.wm; k++) begin
        @(negedge clk);
        chk("dmem_hold", bus.dmem_req_valid, 1'b1);
      end
      bus.dmem_req_ready = 1'b1;
      @(negedge clk);
      bus.dmem_req_ready = 1'b0;
      chk("dmem_drop", bus.dmem_req_valid, 1'b0);
      for (int k = 0; k < t.wd; k++) @(negedge clk);
      bus.dmem_rsp_valid = 1'b1;
      @(negedge clk);
      bus.dmem_rsp_valid = 1'b0;
    end
    o_commit = commit_valid;
    o_cpc    = commit_pc;
    o_wen    = rf_wen;
    o_wsel   = rf_wsel_mem;
    o_cyc    = cyc - t0 + 1;
    @(negedge clk);
    chk("commit_pulse", commit_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] mpc;
    logic [31:0] cpc;
    int          c;
    logic        w, ws, cm;
    inst_t       t;
    int          n;

    // Directed vectors: {instruction, fetch addr, commit pc, cycles, rf_wen, rf_wsel_mem}
    add_vec(mk(K_ALU,   0, 0, 1, 0, 0, 0, 0, 0),                   32'h8000_0000, 32'h8000_0000, 4, 1, 0);
    add_vec(mk(K_ALU,   0, 0, 1, 0, 3, 0, 0, 0),                   32'h8000_0004, 32'h8000_0004, 7, 1, 0);
    add_vec(mk(K_JUMP,  32'h8000_0100, 0, 1, 0, 0, 0, 0, 0),       32'h8000_0008, 32'h8000_0008, 4, 1, 0);
    add_vec(mk(K_LOAD,  0, 32'h8000_1000, 1, 0, 0, 0, 0, 0),       32'h8000_0100, 32'h8000_0100, 6, 1, 1);
    add_vec(mk(K_STORE, 0, 32'h8000_1004, 1, 0, 0, 0, 0, 0),       32'h8000_0104, 32'h8000_0104, 6, 0, 0);
    add_vec(mk(K_ALU,   0, 0, 0, 0, 0, 0, 0, 0),                   32'h8000_0108, 32'h8000_0108, 4, 0, 0);
    add_vec(mk(K_JUMP,  32'hFFFF_FFFC, 0, 1, 0, 0, 0, 0, 0),       32'h8000_010C, 32'h8000_010C, 4, 1, 0);
    add_vec(mk(K_ALU,   0, 0, 1, 0, 0, 0, 0, 0),                   32'hFFFF_FFFC, 32'hFFFF_FFFC, 4, 1, 0);
    add_vec(mk(K_ALU,   0, 0, 1, 0, 0, 0, 0, 0),                   32'h0000_0000, 32'h0000_0000, 4, 1, 0);
    add_vec(mk(K_JUMP,  32'h8000_0000, 0, 0, 0, 0, 0, 0, 0),       32'h0000_0004, 32'h0000_0004, 4, 0, 0);
    add_vec(mk(K_LOAD,  0, 32'h0000_0040, 1, 0, 0, 2, 1, 3),       32'h8000_0000, 32'h8000_0000, 12, 1, 1);

    do_reset();
    mpc = 32'h8000_0000;
    foreach (vq[i]) begin
      do_inst(vq[i].i, vq[i].exp_addr, cpc, c, w, ws, cm);
      chk($sformatf("vec%0d_commit", i), cm, 1'b1);
      chk($sformatf("vec%0d_commit_pc", i), cpc, vq[i].exp_cpc);
      chk($sformatf("vec%0d_cycles", i), c, vq[i].exp_cyc);
      chk($sformatf("vec%0d_rf_wen", i), w, vq[i].exp_wen);
      chk($sformatf("vec%0d_rf_wsel", i), ws, vq[i].exp_wsel);
      mpc = model_next_pc(vq[i].i, mpc);
    end

    // Randomized stream checked against the PC / latency model.
    for (int i = 0; i < 40; i++) begin
      t = mk(kind_t'($urandom_range(0, 3)),
             32'h8000_0000 + ($urandom_range(0, 1023) << 2), $urandom,
             1'($urandom_range(0, 1)), 1'b0,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      do_inst(t, mpc, cpc, c, w, ws, cm);
      chk("rnd_commit", cm, 1'b1);
      chk("rnd_commit_pc", cpc, mpc);
      chk("rnd_cycles", c, model_cycles(t));
      chk("rnd_rf_wen", w, t.wen & (t.kind != K_STORE));
      chk("rnd_rf_wsel", ws, t.kind == K_LOAD);
      mpc = model_next_pc(t, mpc);
    end
    chk("commit_count", n_commits, vq.size() + 40);

    // Misaligned jump target: retires, then halts at the next fetch with code 3.
    t = mk(K_JUMP, 32'h8000_0102, 0, 1, 0, 0, 0, 0, 0);
    do_inst(t, mpc, cpc, c, w, ws, cm);
    chk("misalign_commit_pc", cpc, mpc);
    chk("misalign_no_req", bus.imem_req_valid, 1'b0);
    @(negedge clk);
    chk("misalign_halted", halted, 1'b1);
    chk("misalign_code", exit_code, 2'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("misalign_quiet", bus.imem_req_valid | commit_valid, 1'b0);
    end
    chk("misalign_pc_frozen", pc, 32'h8000_0102);

    // ebreak with a0 == 0: good trap, no commit, nothing further requested.
    do_reset();
    do_inst(mk(K_EBREAK, 0, 0, 0, 1, 0, 0, 0, 0), 32'h8000_0000, cpc, c, w, ws, cm);
    chk("ebreak0_no_commit", cm, 1'b0);
    chk("ebreak0_halted", halted, 1'b1);
    chk("ebreak0_code", exit_code, 2'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ebreak0_quiet", {bus.imem_req_valid, bus.dmem_req_valid, commit_valid, rf_wen}, 4'b0);
    end
    chk("ebreak0_pc_frozen", pc, 32'h8000_0000);
    chk("ebreak0_inst_frozen", inst, 32'h0010_0073);

    // ebreak with a0 != 0 after one ALU instruction: bad trap.
    do_reset();
    do_inst(mk(K_ALU, 0, 0, 1, 0, 0, 0, 0, 0), 32'h8000_0000, cpc, c, w, ws, cm);
    do_inst(mk(K_EBREAK, 0, 0, 0, 0, 0, 0, 0, 0), 32'h8000_0004, cpc, c, w, ws, cm);
    chk("ebreak1_no_commit", cm, 1'b0);
    chk("ebreak1_halted", halted, 1'b1);
    chk("ebreak1_code", exit_code, 2'd1);
    @(negedge clk);
    chk("ebreak1_quiet", bus.imem_req_valid, 1'b0);

    // Fetch accepted, response never arrives: halts after 16 F_WAIT cycles.
    do_reset();
    @(negedge clk);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_code", exit_code, 2'd2);

    // Reset in the middle of M_WAIT, then a stray data response.
    do_reset();
    @(negedge clk);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    dec_is_load = 1'b1; dec_reg_wen = 1'b1; exu_mem_addr = 32'h8000_2000;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_2003;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("mwait_pre_req", bus.dmem_req_valid, 1'b1);
    bus.dmem_req_ready = 1'b1;
    @(negedge clk);
    bus.dmem_req_ready = 1'b0;
    @(negedge clk);
    do_reset();
    bus.dmem_rsp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_fetch_valid", bus.imem_req_valid, 1'b1);
      chk("stray_fetch_addr", bus.imem_req_addr, 32'h8000_0000);
      chk("stray_no_commit", commit_valid | rf_wen | bus.dmem_req_valid, 1'b0);
    end
    bus.dmem_rsp_valid = 1'b0;
    do_inst(mk(K_ALU, 0, 0, 1, 0, 0, 0, 0, 0), 32'h8000_0000, cpc, c, w, ws, cm);
    chk("restart_commit", cm, 1'b1);
    chk("restart_commit_pc", cpc, 32'h8000_0000);
    chk("restart_cycles", c, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: actual=expired required=finished");
    $fatal(1);
  end

endmodule
